// File: rtl/if_id_fifo.sv
// Fetch-to-decode instruction buffer.
// Queues {pc, instr} pairs between fetch and decode.
// The head entry is shown to decode only while the queue holds something.
// When the queue is empty, decode sees an all-zero NOP bubble.
// Every output is decoded from registers; none depends combinationally on an input.
module if_id_fifo #(
   parameter  int WORD_W = 32,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              validF,
   input  logic [WORD_W-1:0] instrF,
   input  logic [WORD_W-1:0] pcF,
   output logic              readyF,
   input  logic              stallD,
   input  logic              flushD,
   output logic              validD,
   output logic [WORD_W-1:0] instrD,
   output logic [WORD_W-1:0] pcD,
   output logic [CNT_W-1:0]  count
);

   localparam int         PTR_W = $clog2(DEPTH);
   localparam [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   logic [2*WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]    wp_q, wp_d;
   logic [PTR_W-1:0]    rp_q, rp_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                push, pop;
   logic [2*WORD_W-1:0] head;

   assign readyF = (count_q != FULL);
   assign validD = (count_q != '0);
   assign count  = count_q;

   // A flush cancels both transfers; the fetch word offered in that cycle is dropped.
   assign push = validF & readyF & ~flushD;
   assign pop  = validD & ~stallD & ~flushD;

   assign head   = mem_q[rp_q];
   assign pcD    = validD ? head[2*WORD_W-1:WORD_W] : '0;
   assign instrD = validD ? head[WORD_W-1:0]        : '0;

   // Pointer and occupancy next state.
   // Full and empty are told apart by the count, so both pointers wrap freely.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flushD) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) wp_d = wp_q + PTR_W'(1);
         if (pop)  rp_d = rp_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   // Pointer and occupancy registers.
   // Reset empties the queue immediately rather than waiting for the next edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Entry storage.
   // It has no reset: a stale entry is never visible, because the outputs are gated by validD.
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= {pcF, instrF};
   end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo with DEPTH=4 and WORD_W=32.
module tb_if_id_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        validF = 1'b0;
   logic [31:0] instrF = '0;
   logic [31:0] pcF = '0;
   logic        readyF;
   logic        stallD = 1'b0;
   logic        flushD = 1'b0;
   logic        validD;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   if_id_fifo #(.WORD_W(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .validF(validF), .instrF(instrF), .pcF(pcF),
      .readyF(readyF), .stallD(stallD), .flushD(flushD), .validD(validD),
      .instrD(instrD), .pcD(pcD), .count(count)
   );

   always #5 clk = ~clk;

   // The instruction word is derived from its PC, so pc and instr can be checked together.
   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Checks the whole decode-side view against the expected head PC and occupancy.
   task automatic chk_head(input string tag, input logic [31:0] pc, input int cnt);
      chk({tag, ".count"}, 32'(count), 32'(cnt));
      chk({tag, ".validD"}, 32'(validD), 32'(cnt != 0));
      chk({tag, ".pcD"}, pcD, (cnt != 0) ? pc : 32'h0);
      chk({tag, ".instrD"}, instrD, (cnt != 0) ? ins_of(pc) : 32'h0);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] pc);
      validF = v;
      pcF    = pc;
      instrF = ins_of(pc);
   endtask

   logic [31:0] q[$];
   int sent;
   int cyc;
   logic do_push, do_pop;

   initial begin
      // Reset state.
      #2;
      chk_head("rst", 32'h0, 0);
      chk("rst.readyF", 32'(readyF), 32'h1);
      #10 rst = 1'b1;
      tick;
      chk_head("post_rst", 32'h0, 0);

      // Streaming: each word appears one cycle after its push, and occupancy stays at 1.
      offer(1'b1, 32'h00); tick; chk_head("s0", 32'h00, 1);
      offer(1'b1, 32'h04); tick; chk_head("s1", 32'h04, 1);
      offer(1'b1, 32'h08); tick; chk_head("s2", 32'h08, 1);
      offer(1'b0, 32'h0);  tick; chk_head("s3", 32'h0, 0);

      // Fill under stall: the head is held while the queue fills.
      stallD = 1'b1;
      offer(1'b1, 32'h100); tick; chk_head("f0", 32'h100, 1);
      offer(1'b1, 32'h104); tick; chk_head("f1", 32'h100, 2);
      offer(1'b1, 32'h108); tick; chk_head("f2", 32'h100, 3);
      offer(1'b1, 32'h10C); tick; chk_head("f3", 32'h100, 4);
      chk("f3.readyF", 32'(readyF), 32'h0);
      offer(1'b1, 32'h110); tick; chk_head("f4_ignored", 32'h100, 4);
      chk("f4.readyF", 32'(readyF), 32'h0);

      // Full with a simultaneous pop: no push this cycle, then the queue accepts again.
      stallD = 1'b0;
      tick; chk_head("fp0", 32'h104, 3);
      chk("fp0.readyF", 32'(readyF), 32'h1);
      tick; chk_head("fp1", 32'h108, 3);
      offer(1'b0, 32'h0);
      tick; chk_head("d0", 32'h10C, 2);
      tick; chk_head("d1", 32'h110, 1);
      tick; chk_head("d2", 32'h0, 0);

      // Flush priority over push and stall.
      stallD = 1'b1;
      offer(1'b1, 32'h200); tick;
      offer(1'b1, 32'h204); tick;
      offer(1'b1, 32'h208); tick; chk_head("fl_pre", 32'h200, 3);
      flushD = 1'b1;
      offer(1'b1, 32'h20C); tick; chk_head("fl0", 32'h0, 0);
      chk("fl0.readyF", 32'(readyF), 32'h1);
      flushD = 1'b0; stallD = 1'b0;
      offer(1'b0, 32'h0); tick; chk_head("fl1_dropped", 32'h0, 0);
      offer(1'b1, 32'h300); tick; chk_head("fl2", 32'h300, 1);
      offer(1'b0, 32'h0); tick; chk_head("fl3", 32'h0, 0);

      // Asynchronous reset in the middle of a cycle with two entries queued.
      stallD = 1'b1;
      offer(1'b1, 32'h400); tick;
      offer(1'b1, 32'h404); tick; chk_head("ar_pre", 32'h400, 2);
      offer(1'b0, 32'h0);
      #3 rst = 1'b0;
      #1 chk_head("ar_now", 32'h0, 0);
      chk("ar_now.readyF", 32'(readyF), 32'h1);
      #2 rst = 1'b1;
      stallD = 1'b0;
      tick; chk_head("ar_post", 32'h0, 0);

      // Wrap-around: ten words through the queue with random stalls, checked against a queue model.
      sent = 0;
      cyc  = 0;
      while ((sent < 10 || q.size() != 0) && cyc < 200) begin
         stallD  = 1'($urandom_range(0, 1));
         offer(sent < 10, 32'h1000 + 32'(sent * 4));
         do_push = (sent < 10) && (q.size() != 4);
         do_pop  = (q.size() != 0) && !stallD;
         if (do_pop)  void'(q.pop_front());
         if (do_push) begin
            q.push_back(pcF);
            sent++;
         end
         tick;
         cyc++;
         chk_head($sformatf("wrap%0d", cyc), (q.size() != 0) ? q[0] : 32'h0, q.size());
      end
      chk("wrap.finished", 32'(cyc < 200), 32'h1);
      offer(1'b0, 32'h0);
      stallD = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised fetch-to-decode buffer: a DEPTH-entry queue of {pc, instr} pairs between the IF and ID stages. It replaces the single-entry IF/ID register so fetch keeps running while decode stalls. It supports valid/ready flow control on the fetch side, stall and flush from the hazard unit, and a zero-word bubble on the decode side when empty. It sits between the instruction-memory read port and the decoder.

## Interface
- WORD_W, 32, width of instruction and PC words
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- validF  input  1  fetch presents a valid {pcF, instrF} this cycle
- instrF  input  WORD_W  fetched instruction
- pcF  input  WORD_W  PC of fetched instruction
- readyF  output  1  queue can accept; = (count != DEPTH)
- stallD  input  1  decode holds the current head
- flushD  input  1  discard all queued entries (branch/exception redirect)
- validD  output  1  head entry valid; = (count != 0)
- instrD  output  WORD_W  head instruction; all-zero when validD=0
- pcD  output  WORD_W  head PC; all-zero when validD=0
- count  output  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH × {pc, instr} registers; write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping modulo DEPTH; count register.
- Push = validF & readyF & !flushD: write {pcF, instrF} at wp; wp ← wp+1.
- Pop = validD & !stallD & !flushD: rp ← rp+1.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any occupancy 1..DEPTH-1.
- Full (count = DEPTH): readyF=0, so no push. A pop in that cycle frees one slot, and readyF rises the next cycle. readyF never depends combinationally on stallD.
- Empty (count = 0): validD=0, instrD=pcD=0 (NOP bubble), so no pop. A push in that cycle makes the entry visible the next cycle. There is no same-cycle bypass.
- Stall: head is held; instrD/pcD/validD are unchanged except when a push fills an empty queue.
- Flush takes priority over push, pop and stall. At the clock edge wp ← 0, rp ← 0, count ← 0. The fetch word offered in the flush cycle is dropped. Next cycle validD=0 and the outputs are zero.
- Storage array contents need not be cleared on reset or flush. Outputs must be zero whenever validD=0.
- Outputs are decoded from registered pointers and storage via a mux of head entry gated by validD; there is no combinational path from any input to any output.

## Timing
- Reset (rst=0, asynchronous): wp=rp=0, count=0, validD=0, instrD=0, pcD=0, readyF=1, applied immediately, not at the next edge. Release is synchronous to clk. Reset mid-operation discards all entries.
- Latency: a push at edge t appears at instrD/pcD after edge t when the queue was empty. Otherwise it appears after all older entries have popped.
- Throughput: one push and one pop per cycle sustained.
- Ordering: strict FIFO; pcD sequence equals accepted pcF sequence.
- Pointer wrap from DEPTH-1 to 0 is seamless; full vs empty is distinguished by count, not pointers.
- flushD and stallD asserted together: flush wins.

## Test plan
- Reset/empty: hold rst=0 mid-cycle with 2 entries queued -> outputs zero immediately, count=0, readyF=1; after release validD=0.
- Streaming: DEPTH=4, push pc 0x00,0x04,0x08 on consecutive cycles, stallD=0 -> pcD shows 0x00,0x04,0x08 one cycle after each push, count never exceeds 1.
- Fill under stall: stallD=1, push 0x100..0x10C (4 words) -> count=4, readyF=0, pcD=0x100 held; 5th validF ignored. Release stall -> pcD 0x100,0x104,0x108,0x10C, then validD=0 and instrD=0.
- Full with simultaneous pop: count=4, stallD=0, validF=1 -> no push that cycle, count=3, readyF=1 next cycle, then accepts.
- Flush priority: count=3, assert flushD with validF=1 and stallD=1 -> next cycle count=0, validD=0, pcD=0, and the offered word is not queued.
- Wrap-around: push/pop 10 words through DEPTH=4 with random stallD -> output order matches input order exactly and count stays consistent with pushes minus pops.
